tpu_cmd_dispatcher: RTL and testbench

TPU_CMD_DISPATCHER -- requirements
Module: tpu_cmd_dispatcher

---
 rtl/tpu_cmd_dispatcher_if.sv | 26 ++
 rtl/tpu_cmd_dispatcher.sv | 124 ++++++++++++
 tb/tb_tpu_cmd_dispatcher.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_cmd_dispatcher_if.sv
// Command push / issue handshake bundle between upstream, dispatcher and compute top.
interface tpu_cmd_dispatcher_if #(
  parameter int unsigned CMD_WIDTH = 64
);
  logic                 push_valid;
  logic [CMD_WIDTH-1:0] push_data;
  logic                 push_ready;
  logic                 flush;
  logic                 cmd_valid;
  logic [CMD_WIDTH-1:0] cmd_data;
  logic                 cmd_ready;
  logic                 busy;
  logic                 done_irq;

  // Upstream producer plus compute-top side, as seen from outside the dispatcher
  modport master (
    output push_valid, push_data, flush, cmd_ready, busy, done_irq,
    input  push_ready, cmd_valid, cmd_data
  );

  // Dispatcher side
  modport slave (
    input  push_valid, push_data, flush, cmd_ready, busy, done_irq,
    output push_ready, cmd_valid, cmd_data
  );
endinterface

// File: rtl/tpu_cmd_dispatcher.sv
// Command queue feeding a registered issue stage, with outstanding-command
// throttling, FENCE ordering (MSB of the command word) and a spurious-done flag.
module tpu_cmd_dispatcher #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned CMD_WIDTH       = 64,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  tpu_cmd_dispatcher_if.slave                    bus,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]        fifo_count,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   idle,
  output logic                                   err_spurious_done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  logic [CMD_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_cmd_valid;
  logic [CMD_WIDTH-1:0] r_cmd_data;
  logic [OW-1:0]        r_outstanding;
  logic                 r_err;

  logic                 w_push_ready;
  logic                 w_push;
  logic                 w_issue;
  logic                 w_stage_free;
  logic                 w_head_avail;
  logic [CMD_WIDTH-1:0] w_head_data;
  logic                 w_fence_ok;
  logic                 w_slot_ok;
  logic                 w_load;
  logic [OW-1:0]        w_out_next;
  logic                 w_err_set;

  // Handshake qualifiers; an empty queue bypasses push_data straight to the stage
  assign w_push_ready = (r_count < CW'(FIFO_DEPTH));
  assign w_push       = bus.push_valid && w_push_ready && !bus.flush;
  assign w_issue      = r_cmd_valid && bus.cmd_ready;
  assign w_stage_free = !r_cmd_valid || w_issue;
  assign w_head_avail = (r_count != '0) || w_push;
  assign w_head_data  = (r_count == '0) ? bus.push_data : r_mem[r_rd_ptr];

  // Outstanding count after this cycle's issue/done events
  always_comb begin
    w_out_next = r_outstanding;
    w_err_set  = 1'b0;
    if (w_issue && !bus.done_irq) begin
      w_out_next = r_outstanding + OW'(1);
    end else if (!w_issue && bus.done_irq) begin
      if (r_outstanding != '0) w_out_next = r_outstanding - OW'(1);
      else                     w_err_set  = 1'b1;
    end
  end

  // A loaded command will issue later, so it needs a slot that stays free
  assign w_slot_ok  = (w_out_next < OW'(MAX_OUTSTANDING));
  // FENCE waits for a fully drained compute top with nothing issuing this cycle
  assign w_fence_ok = (r_outstanding == '0) && !w_issue && !bus.busy;
  assign w_load     = !bus.flush && w_stage_free && w_head_avail && w_slot_ok &&
                      (!w_head_data[CMD_WIDTH-1] || w_fence_ok);

  // Queue storage, no reset needed since count/pointers qualify every read
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.push_data;
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_load);
    end
  end

  // Issue stage register: holds until accepted, reloads in the accept cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_valid <= 1'b0;
      r_cmd_data  <= '0;
    end else if (w_load) begin
      r_cmd_valid <= 1'b1;
      r_cmd_data  <= w_head_data;
    end else if (w_issue) begin
      r_cmd_valid <= 1'b0;
    end
  end

  // Outstanding tracker and sticky spurious-done error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      r_outstanding <= w_out_next;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign bus.push_ready     = w_push_ready;
  assign bus.cmd_valid      = r_cmd_valid;
  assign bus.cmd_data       = r_cmd_data;
  assign fifo_count         = r_count;
  assign outstanding        = r_outstanding;
  assign err_spurious_done  = r_err;
  assign idle               = (r_count == '0) && !r_cmd_valid &&
                              (r_outstanding == '0) && !bus.busy;

endmodule

// File: tb/tb_tpu_cmd_dispatcher.sv
// Directed bench for tpu_cmd_dispatcher: vector table plus multi-cycle sequences.
module tb_tpu_cmd_dispatcher;

  logic       clk;
  logic       rst_n;
  logic [2:0] fifo_count;
  logic [1:0] outstanding;
  logic       idle;
  logic       err_spurious_done;

  int n_cmp = 0;
  int n_err = 0;

  tpu_cmd_dispatcher_if #(.CMD_WIDTH(64)) bus_if ();

  tpu_cmd_dispatcher #(
    .FIFO_DEPTH(4), .CMD_WIDTH(64), .MAX_OUTSTANDING(2)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus_if),
    .fifo_count        (fifo_count),
    .outstanding       (outstanding),
    .idle              (idle),
    .err_spurious_done (err_spurious_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [63:0] pd;
    logic        fl, cr, bz, dn;
    logic        e_pr, e_cv;
    logic [63:0] e_cd;
    int          e_cnt, e_out;
    logic        e_idle, e_err;
  } vec_t;

  localparam int unsigned NV = 13;
  localparam logic [63:0] FENCE_CMD = 64'h8000_0000_0000_0005;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [63:0] pd, input logic fl,
                       input logic cr, input logic bz, input logic dn);
    bus_if.push_valid = pv;
    bus_if.push_data  = pd;
    bus_if.flush      = fl;
    bus_if.cmd_ready  = cr;
    bus_if.busy       = bz;
    bus_if.done_irq   = dn;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic pv, logic [63:0] pd, logic fl, logic cr, logic bz, logic dn,
                              logic e_pr, logic e_cv, logic [63:0] e_cd, int e_cnt, int e_out,
                              logic e_idle, logic e_err);
    vec_t v;
    v.pv = pv; v.pd = pd; v.fl = fl; v.cr = cr; v.bz = bz; v.dn = dn;
    v.e_pr = e_pr; v.e_cv = e_cv; v.e_cd = e_cd; v.e_cnt = e_cnt; v.e_out = e_out;
    v.e_idle = e_idle; v.e_err = e_err;
    return v;
  endfunction

  // Hang guard
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [NV];
    logic [63:0] got [$];
    int          n_iss;

    //      pv  pd          fl cr bz dn | pr cv cd         cnt out idle err
    // In-order issue with 1-cycle latency, one done per issue
    tbl[0]  = mk(1, 64'h1,      0, 0, 0, 0,  1, 1, 64'h1,      0, 0, 0, 0);
    tbl[1]  = mk(1, 64'h2,      0, 1, 0, 0,  1, 1, 64'h2,      0, 1, 0, 0);
    tbl[2]  = mk(1, 64'h3,      0, 1, 0, 1,  1, 1, 64'h3,      0, 1, 0, 0);
    tbl[3]  = mk(0, 64'h0,      0, 1, 0, 1,  1, 0, 64'h0,      0, 1, 0, 0);
    tbl[4]  = mk(0, 64'h0,      0, 1, 0, 1,  1, 0, 64'h0,      0, 0, 1, 0);
    // FENCE behind command A waits for A's done and busy low
    tbl[5]  = mk(1, 64'hA,      0, 0, 0, 0,  1, 1, 64'hA,      0, 0, 0, 0);
    tbl[6]  = mk(1, FENCE_CMD,  0, 1, 0, 0,  1, 0, 64'h0,      1, 1, 0, 0);
    tbl[7]  = mk(0, 64'h0,      0, 1, 1, 0,  1, 0, 64'h0,      1, 1, 0, 0);
    tbl[8]  = mk(0, 64'h0,      0, 1, 1, 1,  1, 0, 64'h0,      1, 0, 0, 0);
    tbl[9]  = mk(0, 64'h0,      0, 1, 1, 0,  1, 0, 64'h0,      1, 0, 0, 0);
    tbl[10] = mk(0, 64'h0,      0, 0, 0, 0,  1, 1, FENCE_CMD,  0, 0, 0, 0);
    tbl[11] = mk(0, 64'h0,      0, 1, 0, 0,  1, 0, 64'h0,      0, 1, 0, 0);
    tbl[12] = mk(0, 64'h0,      0, 0, 0, 1,  1, 0, 64'h0,      0, 0, 1, 0);

    rst_n = 1'b0;
    drive(0, 64'h0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Reset state
    chk("rst_push_ready", 64'(bus_if.push_ready), 64'h1);
    chk("rst_cmd_valid",  64'(bus_if.cmd_valid),  64'h0);
    chk("rst_cmd_data",   bus_if.cmd_data,        64'h0);
    chk("rst_fifo_count", 64'(fifo_count),        64'h0);
    chk("rst_outstanding",64'(outstanding),       64'h0);
    chk("rst_idle",       64'(idle),              64'h1);
    chk("rst_err",        64'(err_spurious_done), 64'h0);

    for (int i = 0; i < int'(NV); i++) begin
      drive(tbl[i].pv, tbl[i].pd, tbl[i].fl, tbl[i].cr, tbl[i].bz, tbl[i].dn);
      tick();
      chk($sformatf("v%0d_push_ready", i), 64'(bus_if.push_ready), 64'(tbl[i].e_pr));
      chk($sformatf("v%0d_cmd_valid", i),  64'(bus_if.cmd_valid),  64'(tbl[i].e_cv));
      if (tbl[i].e_cv) chk($sformatf("v%0d_cmd_data", i), bus_if.cmd_data, tbl[i].e_cd);
      chk($sformatf("v%0d_fifo_count", i), 64'(fifo_count),  64'(tbl[i].e_cnt));
      chk($sformatf("v%0d_outstanding", i),64'(outstanding), 64'(tbl[i].e_out));
      chk($sformatf("v%0d_idle", i),       64'(idle),        64'(tbl[i].e_idle));
      chk($sformatf("v%0d_err", i),        64'(err_spurious_done), 64'(tbl[i].e_err));
    end

    // Backpressure: fill stage + queue, hold data, then pop+push together
    for (int i = 0; i < 5; i++) begin
      drive(1, 64'h10 + 64'(i), 0, 0, 0, 0);
      tick();
      chk($sformatf("bp_hold_%0d", i), bus_if.cmd_data, 64'h10);
    end
    chk("bp_push_ready_full", 64'(bus_if.push_ready), 64'h0);
    chk("bp_count_full",      64'(fifo_count),        64'h4);
    chk("bp_valid_full",      64'(bus_if.cmd_valid),  64'h1);
    drive(1, 64'h15, 0, 0, 0, 0);
    tick();
    chk("bp_count_blocked", 64'(fifo_count),  64'h4);
    chk("bp_data_stable",   bus_if.cmd_data,  64'h10);
    drive(0, 64'h0, 0, 1, 0, 0);
    tick();
    chk("bp_count_pop",   64'(fifo_count),       64'h3);
    chk("bp_data_next",   bus_if.cmd_data,       64'h11);
    chk("bp_out_pop",     64'(outstanding),      64'h1);
    chk("bp_ready_again", 64'(bus_if.push_ready),64'h1);
    drive(1, 64'h15, 0, 1, 0, 1);
    tick();
    chk("bp_count_pushpop", 64'(fifo_count),  64'h3);
    chk("bp_data_pushpop",  bus_if.cmd_data,  64'h12);
    chk("bp_out_pushpop",   64'(outstanding), 64'h1);
    got.delete();
    for (int i = 0; i < 12; i++) begin
      drive(0, 64'h0, 0, 1, 0, outstanding != 2'd0);
      if (bus_if.cmd_valid) got.push_back(bus_if.cmd_data);
      tick();
    end
    drive(0, 64'h0, 0, 0, 0, 0);
    chk("bp_drain_n", 64'(got.size()), 64'h4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("bp_drain_%0d", i), got[i], 64'h12 + 64'(i));
    chk("bp_drain_out", 64'(outstanding),       64'h0);
    chk("bp_drain_err", 64'(err_spurious_done), 64'h0);

    // Outstanding limit: third command waits for a done
    for (int i = 0; i < 3; i++) begin
      drive(1, 64'h21 + 64'(i), 0, 0, 0, 0);
      tick();
    end
    chk("lim_count_pre", 64'(fifo_count), 64'h2);
    chk("lim_data_pre",  bus_if.cmd_data, 64'h21);
    n_iss = 0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 64'h0, 0, 1, 0, 0);
      if (bus_if.cmd_valid) n_iss++;
      tick();
    end
    chk("lim_issued",  64'(n_iss),            64'h2);
    chk("lim_out",     64'(outstanding),      64'h2);
    chk("lim_count",   64'(fifo_count),       64'h1);
    chk("lim_valid",   64'(bus_if.cmd_valid), 64'h0);
    drive(0, 64'h0, 0, 1, 0, 1);
    tick();
    chk("lim_third_valid", 64'(bus_if.cmd_valid), 64'h1);
    chk("lim_third_data",  bus_if.cmd_data,       64'h23);
    chk("lim_out_done",    64'(outstanding),      64'h1);
    drive(0, 64'h0, 0, 1, 0, 0);
    tick();
    chk("lim_out_third", 64'(outstanding),      64'h2);
    chk("lim_valid_end", 64'(bus_if.cmd_valid), 64'h0);
    drive(0, 64'h0, 0, 1, 0, 1);
    tick();
    tick();
    drive(0, 64'h0, 0, 0, 0, 0);
    chk("lim_out_clear", 64'(outstanding), 64'h0);
    chk("lim_idle",      64'(idle),        64'h1);
    chk("lim_err",       64'(err_spurious_done), 64'h0);

    // Spurious done, then flush with 3 queued + 1 presented
    drive(0, 64'h0, 0, 0, 0, 1);
    tick();
    chk("sp_err", 64'(err_spurious_done), 64'h1);
    chk("sp_out", 64'(outstanding),       64'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 64'h31 + 64'(i), 0, 0, 0, 0);
      tick();
    end
    chk("fl_count_pre", 64'(fifo_count), 64'h3);
    drive(1, 64'h99, 1, 0, 0, 0);
    tick();
    chk("fl_count",  64'(fifo_count),       64'h0);
    chk("fl_valid",  64'(bus_if.cmd_valid), 64'h1);
    chk("fl_data",   bus_if.cmd_data,       64'h31);
    chk("fl_out",    64'(outstanding),      64'h0);
    drive(0, 64'h0, 0, 0, 0, 0);
    tick();
    chk("fl_push_dropped", 64'(fifo_count), 64'h0);
    drive(0, 64'h0, 0, 1, 0, 0);
    tick();
    chk("fl_issue_out",   64'(outstanding),       64'h1);
    chk("fl_issue_valid", 64'(bus_if.cmd_valid),  64'h0);
    chk("fl_err_sticky",  64'(err_spurious_done), 64'h1);
    drive(0, 64'h0, 0, 0, 0, 1);
    tick();
    drive(0, 64'h0, 0, 0, 0, 0);
    chk("fl_out_clear", 64'(outstanding), 64'h0);

    // Asynchronous reset mid-operation: 2 queued, 1 outstanding
    for (int i = 0; i < 4; i++) begin
      drive(1, 64'h41 + 64'(i), 0, 0, 0, 0);
      tick();
    end
    drive(0, 64'h0, 0, 1, 0, 0);
    tick();
    chk("ar_count_pre", 64'(fifo_count),  64'h2);
    chk("ar_out_pre",   64'(outstanding), 64'h1);
    drive(0, 64'h0, 0, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_cmd_valid",  64'(bus_if.cmd_valid),  64'h0);
    chk("ar_cmd_data",   bus_if.cmd_data,        64'h0);
    chk("ar_count",      64'(fifo_count),        64'h0);
    chk("ar_out",        64'(outstanding),       64'h0);
    chk("ar_err",        64'(err_spurious_done), 64'h0);
    chk("ar_push_ready", 64'(bus_if.push_ready), 64'h1);
    chk("ar_idle_busy",  64'(idle),              64'h0);
    bus_if.busy = 1'b0;
    #1;
    chk("ar_idle", 64'(idle), 64'h1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 64'h0, 0, 1, 0, 0);
    tick();
    chk("ar_post_valid", 64'(bus_if.cmd_valid), 64'h0);
    chk("ar_post_out",   64'(outstanding),      64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
